// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: scheduler states,
// serial framing bits, and a width helper for index ports.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } sched_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bits needed to index n items; never returns less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Producer-side and transmitter-side signals of the UART TX scheduler.
// master = producers/transmitter environment, slave = the scheduler.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    import uart_pkg::*;

    localparam int IW = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_din;
    logic                 tx_en;
    logic                 tx_rdy;
    logic [IW-1:0]        grant_id;
    logic                 busy;
    logic                 err_timeout;

    modport master (
        output req_valid, req_data, req_last, tx_rdy,
        input  req_ready, tx_din, tx_en, grant_id, busy, err_timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_rdy,
        output req_ready, tx_din, tx_en, grant_id, busy, err_timeout
    );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: first set bit of req searching upward
// from ptr+1 with wrap; one-hot grant plus its index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte producers.
// Define UART_TX_SCHED_FRAME_LOCK_EN to keep a requester's frame contiguous.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            rst,
    uart_tx_sched_if.slave bus
);

    localparam int IW = clog2(NUM_REQ);
    localparam int CW = clog2(TIMEOUT_CYC);

    sched_state_e           state;
    logic [SYNC_STAGES-1:0] rdy_sync;
    logic                   tx_rdy_s;
    logic [IW-1:0]          rr_ptr;
    logic [CW-1:0]          to_cnt;
    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     gnt;
    logic [IW-1:0]          gnt_idx;
    logic                   gnt_any;
    logic                   accept;
    logic [7:0]             gnt_data;
    logic [7:0]             din_q;
    logic                   en_q;
    logic [IW-1:0]          grant_q;
    logic                   err_q;

    // tx_rdy comes from the baud-clock domain; resets to "ready".
    always_ff @(posedge clk) begin
        if (rst) rdy_sync <= '1;
        else     rdy_sync <= SYNC_STAGES'({rdy_sync, bus.tx_rdy});
    end
    assign tx_rdy_s = rdy_sync[SYNC_STAGES-1];

`ifdef UART_TX_SCHED_FRAME_LOCK_EN
    logic          locked;
    logic [IW-1:0] lock_id;

    always_comb begin
        eligible = bus.req_valid;
        if (locked) begin
            eligible          = '0;
            eligible[lock_id] = bus.req_valid[lock_id];
        end
    end
`else
    logic unused_last;
    assign unused_last = ^bus.req_last;
    assign eligible    = bus.req_valid;
`endif

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req (eligible),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign accept = (state == IDLE) && tx_rdy_s && gnt_any;

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_data = bus.req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            din_q   <= '0;
            en_q    <= 1'b0;
            grant_q <= '0;
            err_q   <= 1'b0;
            rr_ptr  <= IW'(NUM_REQ - 1);
            to_cnt  <= '0;
`ifdef UART_TX_SCHED_FRAME_LOCK_EN
            locked  <= 1'b0;
            lock_id <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        din_q   <= gnt_data;
                        grant_q <= gnt_idx;
                        rr_ptr  <= gnt_idx;
                        to_cnt  <= '0;
                        en_q    <= 1'b1;
                        state   <= ISSUE;
`ifdef UART_TX_SCHED_FRAME_LOCK_EN
                        locked  <= !bus.req_last[gnt_idx];
                        lock_id <= gnt_idx;
`endif
                    end
                end
                ISSUE: begin
                    if (!tx_rdy_s) begin
                        en_q  <= 1'b0;
                        state <= BUSY;
                    end else if (to_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        // Transmitter never took the byte: drop it and move on.
                        en_q   <= 1'b0;
                        err_q  <= 1'b1;
                        state  <= IDLE;
`ifdef UART_TX_SCHED_FRAME_LOCK_EN
                        locked <= 1'b0;
`endif
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                BUSY: begin
                    if (tx_rdy_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = accept ? gnt : '0;
    assign bus.tx_din      = din_q;
    assign bus.tx_en       = en_q;
    assign bus.grant_id    = grant_q;
    assign bus.busy        = (state != IDLE);
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: vector table, directed corner cases,
// and randomized byte queues checked against a queue-level round-robin model.
module tb_uart_tx_sched;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(N)) bus ();

    uart_tx_sched #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] ready;
        logic [1:0] gid;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [7:0] qd [N][8];
    bit         ql [N][8];
    int         qlen [N];
    int         qhd [N];
    int         exp_g [64];
    logic [7:0] exp_d [64];
    int         got_g [64];
    int         got_id [64];
    logic [7:0] got_d [64];
    int         n_acc, n_tx, total, m_last;
    bit         m_lock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_rdy    = 1'b1;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        m_last = N - 1;
        m_lock = 1'b0;
    endtask

    task automatic clear_queues();
        for (int r = 0; r < N; r++) begin
            qlen[r] = 0;
            qhd[r]  = 0;
        end
    endtask

    // Expected service order from the queue contents alone: next non-empty
    // requester after the last one served, or the same one while mid-frame.
    task automatic model_order();
        int h [N];
        int g;
        total = 0;
        for (int r = 0; r < N; r++) h[r] = qhd[r];
        for (int n = 0; n < 64; n++) begin
            g = -1;
            if (m_lock) g = m_last;
            else begin
                for (int k = 1; k <= N; k++) begin
                    if (g < 0 && h[(m_last + k) % N] < qlen[(m_last + k) % N]) g = (m_last + k) % N;
                end
            end
            if (g < 0 || h[g] >= qlen[g]) break;
            exp_g[total] = g;
            exp_d[total] = qd[g][h[g]];
`ifdef UART_TX_SCHED_FRAME_LOCK_EN
            m_lock = !ql[g][h[g]];
`endif
            h[g]++;
            m_last = g;
            total++;
        end
    endtask

    task automatic drive_heads();
        for (int r = 0; r < N; r++) begin
            if (qhd[r] < qlen[r]) begin
                bus.req_valid[r]        = 1'b1;
                bus.req_data[8*r +: 8]  = qd[r][qhd[r]];
                bus.req_last[r]         = ql[r][qhd[r]];
            end else begin
                bus.req_valid[r]        = 1'b0;
                bus.req_data[8*r +: 8]  = 8'h00;
                bus.req_last[r]         = 1'b0;
            end
        end
    endtask

    // Requesters present queue heads; transmitter drops tx_rdy 1..3 cycles
    // after tx_en and stays busy 3..6 cycles.
    task automatic serve(input int budget);
        int   pend, tmode, tcnt;
        logic en_prev;
        bit   done, drained;
        pend = -1; tmode = 0; tcnt = 0; en_prev = 1'b0; done = 1'b0;
        n_acc = 0; n_tx = 0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (pend >= 0) qhd[pend]++;
            pend = -1;
            if (bus.tx_en && !en_prev && n_tx < 64) begin
                got_d[n_tx]  = bus.tx_din;
                got_id[n_tx] = int'(bus.grant_id);
                n_tx++;
            end
            en_prev = bus.tx_en;
            case (tmode)
                0: if (bus.tx_en) begin tmode = 1; tcnt = $urandom_range(3, 1); end
                1: begin
                    tcnt--;
                    if (tcnt == 0) begin bus.tx_rdy = 1'b0; tmode = 2; tcnt = $urandom_range(6, 3); end
                end
                default: begin
                    tcnt--;
                    if (tcnt == 0) begin bus.tx_rdy = 1'b1; tmode = 0; end
                end
            endcase
            drive_heads();
            #1;
            drained = 1'b1;
            for (int r = 0; r < N; r++) if (qhd[r] < qlen[r]) drained = 1'b0;
            if (bus.req_ready != '0) begin
                chk("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
                for (int r = 0; r < N; r++) begin
                    if (bus.req_ready[r]) begin
                        pend = r;
                        chk("ready_needs_valid", 32'(bus.req_valid[r]), 32'd1);
                    end
                end
                if (n_acc < 64) got_g[n_acc] = pend;
                n_acc++;
            end
            done = drained && pend < 0 && !bus.busy && tmode == 0;
        end
        chk("serve_done", 32'(done), 32'd1);
        bus.req_valid = '0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_accepts"}, 32'(n_acc), 32'(total));
        chk({tag, "_sends"}, 32'(n_tx), 32'(total));
        for (int n = 0; n < total && n < n_acc && n < n_tx; n++) begin
            chk({tag, "_req"}, 32'(got_g[n]), 32'(exp_g[n]));
            chk({tag, "_gid"}, 32'(got_id[n]), 32'(exp_g[n]));
            chk({tag, "_byte"}, 32'(got_d[n]), 32'(exp_d[n]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [8];
        int         n_en, n_err;
        bit         seen, ok;
        logic [7:0] ed;

        // After reset ptr=3; each row leaves the pointer at its grant.
        tbl[0] = '{valid: 4'b0001, ready: 4'b0001, gid: 2'd0};
        tbl[1] = '{valid: 4'b1111, ready: 4'b0010, gid: 2'd1};
        tbl[2] = '{valid: 4'b0011, ready: 4'b0001, gid: 2'd0};
        tbl[3] = '{valid: 4'b1000, ready: 4'b1000, gid: 2'd3};
        tbl[4] = '{valid: 4'b1010, ready: 4'b0010, gid: 2'd1};
        tbl[5] = '{valid: 4'b0110, ready: 4'b0100, gid: 2'd2};
        tbl[6] = '{valid: 4'b0000, ready: 4'b0000, gid: 2'd0};
        tbl[7] = '{valid: 4'b0101, ready: 4'b0001, gid: 2'd0};

        // Reset values
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.tx_rdy = 1'b1;
        tick();
        chk("rst_tx_din", 32'(bus.tx_din), 32'h0);
        chk("rst_tx_en", 32'(bus.tx_en), 32'h0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_err", 32'(bus.err_timeout), 32'h0);

        // Vector table
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            bus.req_valid = tbl[i].valid;
            bus.req_data  = 32'h1312_1110;
            bus.req_last  = 4'b1111;
            #1;
            chk("tbl_ready", 32'(bus.req_ready), 32'(tbl[i].ready));
            tick();
            bus.req_valid = '0;
            if (tbl[i].ready != '0) begin
                ed = 8'h10 + 8'(tbl[i].gid);
                chk("tbl_din", 32'(bus.tx_din), 32'(ed));
                chk("tbl_gid", 32'(bus.grant_id), 32'(tbl[i].gid));
                chk("tbl_en", 32'(bus.tx_en), 32'd1);
                bus.tx_rdy = 1'b0;
                repeat (4) tick();
                bus.tx_rdy = 1'b1;
                for (int c = 0; c < 10 && bus.busy; c++) tick();
                chk("tbl_back_idle", 32'(bus.busy), 32'd0);
            end else begin
                chk("tbl_no_xfer_busy", 32'(bus.busy), 32'd0);
            end
        end

        // Single byte, transmitter drops tx_rdy 3 cycles after tx_en
        apply_reset();
        bus.req_valid = 4'b0001; bus.req_data = 32'h0000_00A5; bus.req_last = 4'b1111;
        #1;
        chk("single_ready", 32'(bus.req_ready), 32'h1);
        tick();
        chk("single_ready_once", 32'(bus.req_ready), 32'h0);
        chk("single_din", 32'(bus.tx_din), 32'hA5);
        chk("single_en", 32'(bus.tx_en), 32'd1);
        chk("single_busy", 32'(bus.busy), 32'd1);
        bus.req_valid = '0;
        n_en = 1;
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (bus.tx_en) n_en++;
            if (c == 4) bus.tx_rdy = 1'b0;
        end
        chk("single_en_cycles", 32'(n_en), 32'd6);
        tick();
        bus.tx_rdy = 1'b1;
        tick(); tick();
        chk("single_busy_hold", 32'(bus.busy), 32'd1);
        tick();
        chk("single_busy_fall", 32'(bus.busy), 32'd0);
        chk("single_din_held", 32'(bus.tx_din), 32'hA5);

        // Timeout: transmitter never reacts
        apply_reset();
        bus.req_valid = 4'b0011; bus.req_data = 32'h1312_1110; bus.req_last = 4'b1111;
        #1;
        chk("to_first_ready", 32'(bus.req_ready), 32'h1);
        n_en = 0; n_err = 0;
        for (int c = 0; c < 40 && n_err == 0; c++) begin
            tick();
            if (bus.tx_en) n_en++;
            if (bus.err_timeout) n_err++;
        end
        chk("to_en_cycles", 32'(n_en), 32'd16);
        chk("to_err_pulses", 32'(n_err), 32'd1);
        chk("to_idle", 32'(bus.busy), 32'd0);
        chk("to_next_grant", 32'(bus.req_ready), 32'h2);
        bus.req_valid = '0;
        tick();
        chk("to_err_one_cycle", 32'(bus.err_timeout), 32'd0);
        chk("to_din_held", 32'(bus.tx_din), 32'h10);

        // Reset during BUSY, then wait for the synchronised tx_rdy
        apply_reset();
        bus.req_valid = 4'b0100; bus.req_data = 32'h1312_1110; bus.req_last = 4'b1111;
        tick();
        bus.req_valid = '0;
        bus.tx_rdy    = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            tick();
            ok = bus.busy && !bus.tx_en;
        end
        chk("rb_reach_busy", 32'(ok), 32'd1);
        rst = 1'b1;
        tick();
        chk("rb_tx_din", 32'(bus.tx_din), 32'h0);
        chk("rb_tx_en", 32'(bus.tx_en), 32'h0);
        chk("rb_grant_id", 32'(bus.grant_id), 32'h0);
        chk("rb_busy", 32'(bus.busy), 32'h0);
        chk("rb_err", 32'(bus.err_timeout), 32'h0);
        rst = 1'b0;
        repeat (3) tick();
        bus.req_valid = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.req_ready != '0) seen = 1'b1;
        end
        chk("rb_no_grant_while_busy", 32'(seen), 32'd0);
        bus.tx_rdy = 1'b1;
        tick();
        chk("rb_sync_delay", 32'(bus.req_ready), 32'h0);
        tick();
        chk("rb_grant_after_rdy", 32'(bus.req_ready), 32'h4);

        // All four continuously valid: strict rotation
        apply_reset();
        clear_queues();
        for (int r = 0; r < N; r++) begin
            qlen[r] = 2;
            for (int k = 0; k < 2; k++) begin qd[r][k] = 8'h10 + 8'(r); ql[r][k] = 1'b1; end
        end
        model_order();
        serve(1000);
        check_model("rr");
        for (int n = 0; n < 8 && n < n_acc && n < n_tx; n++) begin
            ed = 8'h10 + 8'(n % 4);
            chk("rr_fixed_req", 32'(got_g[n]), 32'(n % 4));
            chk("rr_fixed_byte", 32'(got_d[n]), 32'(ed));
        end

        // Frame of three from req1 against a continuously valid req2
        apply_reset();
        clear_queues();
        qlen[1] = 3;
        qd[1][0] = 8'hA0; ql[1][0] = 1'b0;
        qd[1][1] = 8'hA1; ql[1][1] = 1'b0;
        qd[1][2] = 8'hA2; ql[1][2] = 1'b1;
        qlen[2] = 2;
        qd[2][0] = 8'hB0; ql[2][0] = 1'b1;
        qd[2][1] = 8'hB1; ql[2][1] = 1'b1;
        model_order();
        serve(1000);
        check_model("frame");
        begin
            logic [7:0] fexp [5];
`ifdef UART_TX_SCHED_FRAME_LOCK_EN
            fexp = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1};
`else
            fexp = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2};
`endif
            for (int n = 0; n < 5 && n < n_tx; n++) chk("frame_fixed_byte", 32'(got_d[n]), 32'(fexp[n]));
        end

        // Randomized queues, pointer and lock state carried across rounds
        apply_reset();
        for (int round = 0; round < 4; round++) begin
            clear_queues();
            for (int r = 0; r < N; r++) begin
                qlen[r] = $urandom_range(5, 0);
                for (int k = 0; k < qlen[r]; k++) begin
                    qd[r][k] = 8'($urandom);
                    ql[r][k] = (k == qlen[r] - 1) ? 1'b1 : 1'($urandom_range(1, 0));
                end
            end
            model_order();
            serve(3000);
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter (parallel byte in, serial out, `tx_rdy` status) between NUM_REQ byte producers.
- Arbitrates, latches the winning byte onto the transmitter's `din`, and drives `tx_en` until the transmitter reports it is busy.
- Waits for `tx_rdy` to return high before the next grant.
- Sits between the command/response logic and the UART transmitter, in the system clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 4096, clk cycles allowed in ISSUE for `tx_rdy` to fall before aborting.
- SYNC_STAGES, 2, flops in the `tx_rdy` synchroniser (the transmitter runs on the baud clock).

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a byte.
- `req_data`  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- `req_last`  in  NUM_REQ  byte ends a frame; used only with the optional feature.
- `req_ready`  out  NUM_REQ  one-hot accept; a transfer occurs on an edge where `req_valid[i]` and `req_ready[i]` are both high.
- `tx_din`  out  8  byte to transmitter.
- `tx_en`  out  1  transmit request to transmitter.
- `tx_rdy`  in  1  transmitter idle (asynchronous to `clk`).
- `grant_id`  out  clog2(NUM_REQ)  index of the requester currently being served.
- `busy`  out  1  high whenever state != IDLE.
- `err_timeout`  out  1  one-cycle pulse on an ISSUE abort.

Behaviour:
- Reset:
  - State IDLE.
  - `tx_din`=0, `tx_en`=0, `grant_id`=0, `busy`=0, `err_timeout`=0.
  - RR pointer=NUM_REQ-1, so requester 0 has first priority.
  - Synchroniser flops=1, timeout counter=0.
- `tx_rdy_s` is `tx_rdy` after SYNC_STAGES flops; only `tx_rdy_s` is used.
- IDLE:
  - Grant is combinational: the first asserted `req_valid` searching from pointer+1 upward, with wrap.
  - `req_ready[g]`=1 only if state==IDLE, `tx_rdy_s`=1 and `req_valid[g]`=1; all other `req_ready` bits are 0.
  - On transfer: `tx_din`<=`req_data[g]`, `grant_id`<=g, pointer<=g, counter<=0, state<=ISSUE.
  - Acceptance rate is at most one byte per transmission.
- ISSUE:
  - `tx_en`=1 (registered; first high the cycle after transfer).
  - If `tx_rdy_s`==0: `tx_en`<=0, state<=BUSY.
  - Else if counter==TIMEOUT_CYC-1: `tx_en`<=0, `err_timeout` pulses, state<=IDLE; the byte is dropped.
  - Otherwise counter increments.
- BUSY: `tx_en`=0; when `tx_rdy_s`==1, state<=IDLE. New grants are possible that same cycle.
- `tx_din` and `grant_id` hold stable from transfer until the next transfer.
- If no requests are pending, stay in IDLE with outputs held.
- If `req_valid` drops in IDLE before transfer, there is no transfer. Requesters must hold data while valid.
- Starvation-free: with all valid, grant order is 0,1,2,3,0,…
- `rst` mid-transmission returns to the reset values next edge. The transmitter byte in flight is not cancelled. The scheduler then waits for `tx_rdy_s`=1 in IDLE before granting.

Optional Feature:
- Macro UART_TX_SCHED_FRAME_LOCK_EN.
- Defined:
  - After a transfer with `req_last[g]`=0, the scheduler is locked to g: only requester g is eligible in IDLE until it transfers a byte with `req_last`=1.
  - A timeout abort also clears the lock.
  - Frames from different requesters never interleave.
- Undefined: `req_last` is ignored (port kept for interface stability); arbitration is per byte.

Decomposition:
- Package `uart_pkg`:
  - State enum (IDLE, ISSUE, BUSY).
  - START/STOP bit constants shared with the UART transmitter.
  - Function clog2 for `grant_id` width.
- Sub-module `rr_arbiter`: combinational round-robin pick from request vector and pointer; outputs one-hot grant and index. Reusable by a future RX-side dispatcher.
- Synchroniser inline.

Test Plan:
- Single byte: `req_valid`=4'b0001, data 8'hA5, transmitter model drops `tx_rdy` 3 cycles after `tx_en` -> `req_ready[0]` one cycle; `tx_din`=8'hA5; `tx_en` high until `tx_rdy_s` low; `busy` falls after `tx_rdy` returns.
- All four requesters valid continuously with data 8'h10..8'h13 -> serialized bytes 8'h10,11,12,13,10 in that order; `grant_id` 0,1,2,3,0.
- Transmitter never drops `tx_rdy`, TIMEOUT_CYC=16 -> `tx_en` high exactly 16 cycles; `err_timeout` pulses once; scheduler back in IDLE and grants next requester.
- `rst` asserted during BUSY -> next cycle all outputs at reset values; no grant until `tx_rdy_s`=1.
- With UART_TX_SCHED_FRAME_LOCK_EN, req1 sends 3 bytes (last on third) while req2 is valid throughout -> bytes from req1 ×3, then req2. Without the macro -> req1, req2, req1, req2 alternation.
- `tx_rdy` held low at end of reset with `req_valid`=1 -> no `req_ready` until `tx_rdy_s` rises.
